// File: rtl/fpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_pkg : shared types and constants for the FPU normalise/round   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  localparam int EXP_W  = 6;
  localparam int FRAC_W = 25;
  localparam int MANT_W = 29;

  // Exponent constants are one bit wider to match the internal exponent register.
  localparam logic [EXP_W:0] BIAS    = 7'd31;
  localparam logic [EXP_W:0] EXP_MAX = 7'd63;

endpackage
`default_nettype wire

// File: rtl/fpu_round_rne.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_round_rne : round-to-nearest-even on a normalised mantissa     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] mant_in,
  output logic [MANT_W-1:0] mant_out,
  output logic              carry,
  output logic              inexact
);

  logic              guard;
  logic              sticky;
  logic              lsb;
  logic              round_up;
  logic [MANT_W-1:0] sum;

  assign guard    = mant_in[1];
  assign sticky   = mant_in[0];
  assign lsb      = mant_in[2];
  assign round_up = guard && (sticky || lsb);
  assign inexact  = guard || sticky;

  assign sum   = mant_in + {{(MANT_W-3){1'b0}}, round_up, 2'b00};
  assign carry = sum[MANT_W-1];

  // A carry out of the hidden bit means the fraction wrapped to zero; renormalise by one.
  assign mant_out = carry ? {1'b0, sum[MANT_W-1:1]} : sum;

endmodule
`default_nettype wire

// File: rtl/fpu_norm_round.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_norm_round : bit-serial normalise, RNE round and pack          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_norm_round
  import fpu_pkg::*;
(
  input  logic              clock100KHz,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       data_out,
  output logic [3:0]        status_out,
  output logic              flags_out
);

  norm_state_t       state, state_next;
  logic              sign_q, sign_next;
  logic [EXP_W:0]    exp_q, exp_next;
  logic [MANT_W-1:0] mant_q, mant_next;
  logic [31:0]       data_next;
  logic [3:0]        status_next;
  logic              flags_next;

  logic [MANT_W-1:0] rnd_mant;
  logic              rnd_carry;
  logic              rnd_inexact;
  logic [EXP_W:0]    exp_rnd;

  fpu_round_rne u_round (
    .mant_in  (mant_q),
    .mant_out (rnd_mant),
    .carry    (rnd_carry),
    .inexact  (rnd_inexact)
  );

  assign exp_rnd = exp_q + {{EXP_W{1'b0}}, rnd_carry};

  always_comb begin
    state_next  = state;
    sign_next   = sign_q;
    exp_next    = exp_q;
    mant_next   = mant_q;
    data_next   = data_out;
    status_next = status_out;
    flags_next  = flags_out;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_next  = in_sign;
          exp_next   = {1'b0, in_exp};
          mant_next  = in_mant;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (mant_q == '0) begin
          data_next   = 32'h0000_0000;
          status_next = ST_EXACT;
          flags_next  = 1'b0;
          state_next  = DONE;
        end else if (mant_q[MANT_W-1]) begin
          // Bits shifted out on the right fold into the sticky bit.
          mant_next  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_next   = exp_q + 7'd1;
          state_next = ROUND;
        end else if (mant_q[MANT_W-2]) begin
          state_next = ROUND;
        end else if (exp_q == 7'd1) begin
          data_next   = {sign_q, 31'b0};
          status_next = ST_UNDERFLOW;
          flags_next  = 1'b1;
          state_next  = DONE;
        end else begin
          mant_next = {mant_q[MANT_W-2:0], 1'b0};
          exp_next  = exp_q - 7'd1;
        end
      end

      ROUND: begin
        mant_next = rnd_mant;
        exp_next  = exp_rnd;
        if (exp_rnd >= EXP_MAX) begin
          data_next   = {sign_q, EXP_MAX[EXP_W-1:0], {FRAC_W{1'b0}}};
          status_next = ST_OVERFLOW;
        end else begin
          data_next   = {sign_q, exp_rnd[EXP_W-1:0], rnd_mant[FRAC_W+1:2]};
          status_next = rnd_inexact ? ST_INEXACT : ST_EXACT;
        end
        flags_next = (status_next != ST_EXACT);
        state_next = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      data_out   <= 32'h0000_0000;
      status_out <= 4'b0000;
      flags_out  <= 1'b0;
    end else begin
      state      <= state_next;
      sign_q     <= sign_next;
      exp_q      <= exp_next;
      mant_q     <= mant_next;
      in_ready   <= (state_next == IDLE);
      out_valid  <= (state_next == DONE);
      data_out   <= data_next;
      status_out <= status_next;
      flags_out  <= flags_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_norm_round.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fpu_norm_round : vector table + scoreboard bench                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fpu_norm_round;

  typedef struct {
    logic        sign;
    logic [5:0]  exp;
    logic [28:0] mant;
    logic [31:0] data;
    logic [3:0]  status;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_exp;
  logic [28:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        flags_out;

  int   passed;
  int   total;
  vec_t vecs[16];
  exp_t sb[$];

  fpu_norm_round dut (
    .clock100KHz (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .status_out  (status_out),
    .flags_out   (flags_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),   32'd1);
    check({tag, "_out_valid"}, 32'(out_valid),  32'd0);
    check({tag, "_data"},      data_out,        32'h0);
    check({tag, "_status"},    32'(status_out), 32'd0);
    check({tag, "_flags"},     32'(flags_out),  32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    exp_t e;
    exp_t got;
    int   n;
    int   lat;
    @(negedge clk);
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.data   = v.data;
    e.status = v.status;
    e.lat    = v.lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
      sb.delete();
      return;
    end
    got = sb.pop_front();
    check("data",     data_out,         got.data);
    check("status",   32'(status_out),  32'(got.status));
    check("flags",    32'(flags_out),   32'(got.status != 4'b0001));
    check("latency",  lat,              got.lat);
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid",  32'(out_valid),  32'd1);
      check("hold_ready",  32'(in_ready),   32'd0);
      check("hold_data",   data_out,        got.data);
      check("hold_status", 32'(status_out), 32'(got.status));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready),  32'd1);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;

    vecs[0]  = '{1'b0, 6'd31, 29'h0800_0000, 32'h3E00_0000, 4'b0001, 3};
    vecs[1]  = '{1'b0, 6'd31, 29'h1000_0000, 32'h4000_0000, 4'b0001, 3};
    vecs[2]  = '{1'b0, 6'd31, 29'h0800_0002, 32'h3E00_0000, 4'b0010, 3};
    vecs[3]  = '{1'b0, 6'd31, 29'h0800_0006, 32'h3E00_0002, 4'b0010, 3};
    vecs[4]  = '{1'b0, 6'd62, 29'h1000_0000, 32'h7E00_0000, 4'b0100, 3};
    vecs[5]  = '{1'b0, 6'd1,  29'h0400_0000, 32'h0000_0000, 4'b1000, 2};
    vecs[6]  = '{1'b0, 6'd31, 29'h0000_0004, 32'h0C00_0000, 4'b0001, 28};
    vecs[7]  = '{1'b1, 6'd20, 29'h0000_0000, 32'h0000_0000, 4'b0001, 2};
    vecs[8]  = '{1'b1, 6'd31, 29'h0800_0000, 32'hBE00_0000, 4'b0001, 3};
    vecs[9]  = '{1'b0, 6'd31, 29'h0FFF_FFFE, 32'h4000_0000, 4'b0010, 3};
    vecs[10] = '{1'b0, 6'd31, 29'h1000_0001, 32'h4000_0000, 4'b0010, 3};
    vecs[11] = '{1'b1, 6'd3,  29'h0100_0000, 32'h8000_0000, 4'b1000, 4};
    vecs[12] = '{1'b0, 6'd31, 29'h0400_0000, 32'h3C00_0000, 4'b0001, 4};
    vecs[13] = '{1'b1, 6'd62, 29'h0FFF_FFFE, 32'hFE00_0000, 4'b0100, 3};
    vecs[14] = '{1'b0, 6'd31, 29'h0800_0003, 32'h3E00_0001, 4'b0010, 3};
    vecs[15] = '{1'b0, 6'd63, 29'h0800_0000, 32'h7E00_0000, 4'b0100, 3};

    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], 0);
    end

    // Backpressure: result must hold steady while the consumer stalls.
    run_vec(vecs[3], 10);

    // Reset during SHIFT discards the operation.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 6'd31;
    in_mant  = 29'h0000_0004;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("shift_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("shift_reset_discard", 32'(out_valid), 32'd0);
    run_vec(vecs[0], 0);

    // Reset while a result is waiting in DONE.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 6'd31;
    in_mant  = 29'h1000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("done_pending_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_values("done_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("done_reset_discard", 32'(out_valid), 32'd0);
    run_vec(vecs[1], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
